// File: rtl/register_file_sb_if.sv
// Bus bundle for register_file_sb: read ports, issue port, two writeback ports and debug outputs.
// The slave modport faces the register file, the master modport faces issue/writeback logic.
interface register_file_sb_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [AW-1:0]   rs1_sel_in;
    logic [AW-1:0]   rs2_sel_in;
    logic [XLEN-1:0] rs1_value_out;
    logic [XLEN-1:0] rs2_value_out;
    logic            rs1_busy_out;
    logic            rs2_busy_out;
    logic            issue_valid_in;
    logic [AW-1:0]   issue_rd_in;
    logic            wb0_en_in;
    logic [AW-1:0]   wb0_rd_in;
    logic [XLEN-1:0] wb0_data_in;
    logic            wb1_en_in;
    logic [AW-1:0]   wb1_rd_in;
    logic [XLEN-1:0] wb1_data_in;
    logic [NREGS-1:0] busy_vec_out;
    logic [AW-1:0]   last_rd_out;
    logic [31:0]     write_count_out;

    modport slave (
        input  rs1_sel_in, rs2_sel_in,
        output rs1_value_out, rs2_value_out, rs1_busy_out, rs2_busy_out,
        input  issue_valid_in, issue_rd_in,
        input  wb0_en_in, wb0_rd_in, wb0_data_in,
        input  wb1_en_in, wb1_rd_in, wb1_data_in,
        output busy_vec_out, last_rd_out, write_count_out
    );

    modport master (
        output rs1_sel_in, rs2_sel_in,
        input  rs1_value_out, rs2_value_out, rs1_busy_out, rs2_busy_out,
        output issue_valid_in, issue_rd_in,
        output wb0_en_in, wb0_rd_in, wb0_data_in,
        output wb1_en_in, wb1_rd_in, wb1_data_in,
        input  busy_vec_out, last_rd_out, write_count_out
    );
endinterface

// File: rtl/register_file_sb.sv
// Dual-writeback register file with per-register busy scoreboard and committed-write counter.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data onto the read ports.
module register_file_sb #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input logic                clk,
    input logic                rst_n,
    register_file_sb_if.slave  bus
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic [AW-1:0]    last_rd_q, last_rd_d;
    logic [31:0]      write_count_q;
    logic [31:0]      write_count_d;

    logic       commit0, commit1, same_rd;
    logic [1:0] commit_inc;

    assign commit0    = bus.wb0_en_in && (bus.wb0_rd_in != '0);
    assign commit1    = bus.wb1_en_in && (bus.wb1_rd_in != '0);
    assign same_rd    = commit0 && commit1 && (bus.wb0_rd_in == bus.wb1_rd_in);
    // A double commit to one register is a single architectural write.
    assign commit_inc = {1'b0, commit1} + {1'b0, commit0 && !same_rd};

    assign write_count_d = write_count_q + 32'(commit_inc);

    always_comb begin
        regs_d = regs_q;
        if (commit0) regs_d[bus.wb0_rd_in] = bus.wb0_data_in;
        // Applied second so the load port wins a same-rd collision.
        if (commit1) regs_d[bus.wb1_rd_in] = bus.wb1_data_in;
    end

    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < NREGS; i++) begin
            if (bus.issue_valid_in && (bus.issue_rd_in == AW'(i))) begin
                busy_d[i] = 1'b1;
            end else if ((commit0 && (bus.wb0_rd_in == AW'(i))) ||
                         (commit1 && (bus.wb1_rd_in == AW'(i)))) begin
                busy_d[i] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        last_rd_d = last_rd_q;
        if (commit1) begin
            last_rd_d = bus.wb1_rd_in;
        end else if (commit0) begin
            last_rd_d = bus.wb0_rd_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            busy_q        <= '0;
            last_rd_q     <= '0;
            write_count_q <= '0;
        end else begin
            regs_q        <= regs_d;
            busy_q        <= busy_d;
            last_rd_q     <= last_rd_d;
            write_count_q <= write_count_d;
        end
    end

    logic [AW-1:0]   rd_sel  [2];
    logic [XLEN-1:0] rd_val  [2];
    logic            rd_busy [2];

    assign rd_sel[0] = bus.rs1_sel_in;
    assign rd_sel[1] = bus.rs2_sel_in;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_val[p]  = regs_q[rd_sel[p]];
            rd_busy[p] = busy_q[rd_sel[p]];
`ifdef REGFILE_BYPASS_EN
            if (commit1 && (bus.wb1_rd_in == rd_sel[p])) begin
                rd_val[p]  = bus.wb1_data_in;
                rd_busy[p] = bus.issue_valid_in && (bus.issue_rd_in == rd_sel[p]);
            end else if (commit0 && (bus.wb0_rd_in == rd_sel[p])) begin
                rd_val[p]  = bus.wb0_data_in;
                rd_busy[p] = bus.issue_valid_in && (bus.issue_rd_in == rd_sel[p]);
            end
`endif
            if (rd_sel[p] == '0) begin
                rd_val[p]  = '0;
                rd_busy[p] = 1'b0;
            end
        end
    end

    assign bus.rs1_value_out   = rd_val[0];
    assign bus.rs2_value_out   = rd_val[1];
    assign bus.rs1_busy_out    = rd_busy[0];
    assign bus.rs2_busy_out    = rd_busy[1];
    assign bus.busy_vec_out    = busy_q;
    assign bus.last_rd_out     = last_rd_q;
    assign bus.write_count_out = write_count_q;
endmodule
